// File: rtl/instr_encoder.sv
// instr_encoder: decoded fields -> RV32I word, 2-stage valid/ready.
// Stage 1 validates and holds the record, stage 2 holds the packed word.
module instr_encoder #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_fmt,
  input  logic [6:0]           in_opcode,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [31:0]          out_addr,
  input  logic                 addr_load,
  input  logic [31:0]          addr_base_in,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [2:0] F_R = 3'd0;
  localparam logic [2:0] F_I = 3'd1;
  localparam logic [2:0] F_S = 3'd2;
  localparam logic [2:0] F_B = 3'd3;
  localparam logic [2:0] F_U = 3'd4;
  localparam logic [2:0] F_J = 3'd5;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [1:0]  code;
  } s1_t;

  s1_t         s1;
  logic        s1_valid;
  logic        s2_valid;
  logic        s2_free;
  logic        s1_moves;
  logic        drop;
  logic        xfer;
  logic        range_err;
  logic [1:0]  code;
  logic [31:0] word;
  logic [31:0] addr;

  logic i_ok;
  logic b_ok;
  logic j_ok;

  assign i_ok = &in_imm[31:11] | ~|in_imm[31:11];
  assign b_ok = &in_imm[31:12] | ~|in_imm[31:12];
  assign j_ok = &in_imm[31:20] | ~|in_imm[31:20];

  always_comb begin
    range_err = 1'b0;
    unique case (in_fmt)
      F_I, F_S: range_err = !i_ok;
      F_B:      range_err = !b_ok || in_imm[0];
      F_J:      range_err = !j_ok || in_imm[0];
      F_U:      range_err = |in_imm[11:0];
      default:  range_err = 1'b0;
    endcase
  end

  // Highest-priority fault wins: format, then opcode, then range
  always_comb begin
    code = 2'd0;
    if (in_fmt > F_J)
      code = 2'd1;
    else if (in_opcode[1:0] != 2'b11)
      code = 2'd2;
    else if (range_err)
      code = 2'd3;
  end

  assign s2_free  = !s2_valid || out_ready;
  assign s1_moves = s1_valid && s2_free;
  assign in_ready = !s1_valid || s1_moves;
  assign drop     = s1_moves && (s1.code != 2'd0);
  assign xfer     = s2_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst)
      s1_valid <= 1'b0;
    else if (in_ready)
      s1_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1.fmt    <= in_fmt;
      s1.opcode <= in_opcode;
      s1.funct3 <= in_funct3;
      s1.funct7 <= in_funct7;
      s1.rd     <= in_rd;
      s1.rs1    <= in_rs1;
      s1.rs2    <= in_rs2;
      s1.imm    <= in_imm;
      s1.code   <= code;
    end
  end

  always_comb begin
    word = {25'd0, s1.opcode};
    unique case (1'b1)
      s1.fmt == F_R:
        word = {s1.funct7, s1.rs2, s1.rs1,
                s1.funct3, s1.rd, s1.opcode};
      s1.fmt == F_I:
        word = {s1.imm[11:0], s1.rs1,
                s1.funct3, s1.rd, s1.opcode};
      s1.fmt == F_S:
        word = {s1.imm[11:5], s1.rs2, s1.rs1,
                s1.funct3, s1.imm[4:0], s1.opcode};
      s1.fmt == F_B:
        word = {s1.imm[12], s1.imm[10:5],
                s1.rs2, s1.rs1, s1.funct3,
                s1.imm[4:1], s1.imm[11], s1.opcode};
      s1.fmt == F_U:
        word = {s1.imm[31:12], s1.rd, s1.opcode};
      s1.fmt == F_J:
        word = {s1.imm[20], s1.imm[10:1],
                s1.imm[11], s1.imm[19:12],
                s1.rd, s1.opcode};
      default:
        word = {25'd0, s1.opcode};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      out_instr <= 32'd0;
    end else if (s1_moves) begin
      s2_valid <= (s1.code == 2'd0);
      if (s1.code == 2'd0)
        out_instr <= word;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_code  <= 2'd0;
      err_count <= '0;
    end else begin
      err_pulse <= drop;
      if (drop) begin
        err_code <= s1.code;
        if (!(&err_count))
          err_count <= err_count + ERR_CNT_W'(1);
      end
    end
  end

  // A load overrides the increment; the word leaving now keeps the old address
  always_ff @(posedge clk) begin
    if (rst)
      addr <= ADDR_BASE;
    else if (addr_load)
      addr <= addr_base_in;
    else if (xfer)
      addr <= addr + 32'd4;
  end

  assign out_valid = s2_valid;
  assign out_addr  = addr;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: random and directed checks of instr_encoder
// against an arithmetic model of RV32I field packing.
module tb_instr_encoder;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_fmt = '0;
  logic [6:0]    in_opcode = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [4:0]    in_rd = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [31:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [31:0]   out_addr;
  logic          addr_load = 1'b0;
  logic [31:0]   addr_base_in = '0;
  logic          err_pulse;
  logic [1:0]    err_code;
  logic [CW-1:0] err_count;

  instr_encoder #(.ADDR_BASE(32'h0), .ERR_CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .addr_load(addr_load), .addr_base_in(addr_base_in),
    .err_pulse(err_pulse), .err_code(err_code),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } rec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  rec_t        stim[$];
  logic [31:0] obs_i[$];
  logic [31:0] obs_a[$];
  logic [1:0]  obs_c[$];
  bit          run_done;

  function automatic rec_t mk(input logic [2:0] fmt,
    input logic [6:0] op, input logic [2:0] f3,
    input logic [6:0] f7, input logic [4:0] rd,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [31:0] imm);
    rec_t r;
    r.fmt = fmt; r.op = op; r.f3 = f3; r.f7 = f7;
    r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
    return r;
  endfunction

  function automatic logic [31:0] bits(input logic [31:0] v,
    input int lo, input int n);
    return (v >> lo) & ((32'd1 << n) - 32'd1);
  endfunction

  function automatic logic [31:0] sx(input logic [31:0] v,
    input int n);
    return $signed(v << (32 - n)) >>> (32 - n);
  endfunction

  // Drop code from the numeric range each format can represent
  function automatic int model_code(input rec_t r);
    int s;
    s = $signed(r.imm);
    if (r.fmt > 5) return 1;
    if (r.op % 4 != 3) return 2;
    case (r.fmt)
      1, 2: if (s < -2048 || s > 2047) return 3;
      3: if (s < -4096 || s > 4095 || s % 2 != 0) return 3;
      5: if (s < -(1 << 20) || s > (1 << 20) - 1 || s % 2 != 0)
           return 3;
      4: if (r.imm % 4096 != 0) return 3;
      default: ;
    endcase
    return 0;
  endfunction

  function automatic logic [31:0] model_word(input rec_t r);
    logic [31:0] w;
    logic [31:0] rd7, rs15, rs20, f12;
    rd7 = 32'(r.rd) << 7;
    rs15 = 32'(r.rs1) << 15;
    rs20 = 32'(r.rs2) << 20;
    f12 = 32'(r.f3) << 12;
    w = 32'(r.op);
    case (r.fmt)
      0: w |= (32'(r.f7) << 25) | rs20 | rs15 | f12 | rd7;
      1: w |= (bits(r.imm, 0, 12) << 20) | rs15 | f12 | rd7;
      2: w |= (bits(r.imm, 5, 7) << 25) | rs20 | rs15 | f12
            | (bits(r.imm, 0, 5) << 7);
      3: w |= (bits(r.imm, 12, 1) << 31)
            | (bits(r.imm, 5, 6) << 25) | rs20 | rs15 | f12
            | (bits(r.imm, 1, 4) << 8) | (bits(r.imm, 11, 1) << 7);
      4: w |= (r.imm & 32'hFFFF_F000) | rd7;
      5: w |= (bits(r.imm, 20, 1) << 31)
            | (bits(r.imm, 1, 10) << 21)
            | (bits(r.imm, 11, 1) << 20)
            | (bits(r.imm, 12, 8) << 12) | rd7;
      default: ;
    endcase
    return w;
  endfunction

  // Core-style immediate decode, used for the round-trip property
  function automatic logic [31:0] decode_imm(input logic [2:0] fmt,
    input logic [31:0] w);
    case (fmt)
      1: return sx(bits(w, 20, 12), 12);
      2: return sx((bits(w, 25, 7) << 5) | bits(w, 7, 5), 12);
      3: return sx((bits(w, 31, 1) << 12) | (bits(w, 7, 1) << 11)
                 | (bits(w, 25, 6) << 5) | (bits(w, 8, 4) << 1), 13);
      4: return w & 32'hFFFF_F000;
      5: return sx((bits(w, 31, 1) << 20) | (bits(w, 12, 8) << 12)
                 | (bits(w, 20, 1) << 11) | (bits(w, 21, 10) << 1), 21);
      default: return 32'd0;
    endcase
  endfunction

  function automatic rec_t rnd_rec();
    rec_t r;
    logic [31:0] raw;
    r.fmt = ($urandom_range(0, 19) == 0) ?
            3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
    r.op = ($urandom_range(0, 15) == 0) ? 7'($urandom) :
           7'($urandom_range(0, 31) * 4 + 3);
    r.f3 = 3'($urandom);
    r.f7 = 7'($urandom);
    r.rd = 5'($urandom);
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    raw = $urandom;
    r.imm = raw;
    if ($urandom_range(0, 3) != 0) begin
      case (r.fmt)
        1, 2: r.imm = $signed(raw << 20) >>> 20;
        3: r.imm = ($signed(raw << 19) >>> 19) & ~32'd1;
        4: r.imm = raw & 32'hFFFF_F000;
        5: r.imm = ($signed(raw << 11) >>> 11) & ~32'd1;
        default: r.imm = raw;
      endcase
    end
    return r;
  endfunction

  task automatic drive(input rec_t r);
    in_fmt = r.fmt; in_opcode = r.op;
    in_funct3 = r.f3; in_funct7 = r.f7;
    in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2;
    in_imm = r.imm;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; addr_load = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Streams stim[] and records every transfer and every drop code
  task automatic run(input int rdy_pct, input int gap_pct);
    obs_i.delete(); obs_a.delete(); obs_c.delete();
    run_done = 1'b0;
    fork
      begin : drv
        int guard;
        guard = 0;
        while (stim.size() > 0 && guard < 5000) begin
          @(negedge clk);
          guard++;
          if ($urandom_range(0, 99) < gap_pct) begin
            in_valid = 1'b0;
          end else begin
            drive(stim[0]);
            in_valid = 1'b1;
          end
          #2;
          if (in_valid && in_ready) void'(stim.pop_front());
        end
        @(negedge clk);
        in_valid = 1'b0;
        run_done = 1'b1;
      end
      begin : mon
        int idle;
        int guard;
        idle = 0;
        guard = 0;
        while (idle < 6 && guard < 6000) begin
          @(negedge clk);
          guard++;
          out_ready = run_done || ($urandom_range(0, 99) < rdy_pct);
          #2;
          if (out_valid && out_ready) begin
            obs_i.push_back(out_instr);
            obs_a.push_back(out_addr);
          end
          if (err_pulse) obs_c.push_back(err_code);
          if (run_done && !out_valid && !err_pulse) idle++;
          else idle = 0;
        end
      end
    join
    if (stim.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL run_timeout left=%0d want 0", stim.size());
      stim.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_chk++; if (out_instr !== 32'd0) begin n_fail++;
      $display("FAIL rst_out_instr got %h want 0", out_instr); end
    n_chk++; if (out_addr !== 32'd0) begin n_fail++;
      $display("FAIL rst_out_addr got %h want 0", out_addr); end
    n_chk++; if (err_pulse !== 1'b0) begin n_fail++;
      $display("FAIL rst_err_pulse got %b want 0", err_pulse); end
    n_chk++; if (err_code !== 2'd0) begin n_fail++;
      $display("FAIL rst_err_code got %0d want 0", err_code); end
    n_chk++; if (err_count !== '0) begin n_fail++;
      $display("FAIL rst_err_count got %0d want 0", err_count); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_itype_latency();
    do_reset();
    drive(mk(1, 7'h13, 0, 0, 1, 0, 0, 32'hFFFF_FFFF));
    in_valid = 1'b1; out_ready = 1'b1;
    #2;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL lat_accept in_ready=%b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL lat_n1 out_valid=%b want 0", out_valid); end
    @(negedge clk);
    #2;
    n_chk++; if (out_valid !== 1'b1) begin n_fail++;
      $display("FAIL lat_n2 out_valid=%b want 1", out_valid); end
    n_chk++; if (out_instr !== 32'hFFF0_0093) begin n_fail++;
      $display("FAIL lat_instr got %h want fff00093", out_instr); end
    n_chk++; if (out_addr !== 32'd0) begin n_fail++;
      $display("FAIL lat_addr got %h want 0", out_addr); end
    @(negedge clk);
  endtask

  task automatic test_directed_stream();
    logic [31:0] ew[3];
    ew[0] = 32'hFE00_0EE3;
    ew[1] = 32'h0010_00EF;
    ew[2] = 32'h1234_52B7;
    do_reset();
    stim.push_back(mk(3, 7'h63, 0, 0, 0, 0, 0, 32'hFFFF_FFFC));
    stim.push_back(mk(5, 7'h6F, 0, 0, 1, 0, 0, 32'h0000_0800));
    stim.push_back(mk(4, 7'h37, 0, 0, 5, 0, 0, 32'h1234_5000));
    run(100, 0);
    n_chk++; if (obs_i.size() != 3) begin n_fail++;
      $display("FAIL dir_count got %0d want 3", obs_i.size()); end
    for (int i = 0; i < 3 && i < obs_i.size(); i++) begin
      n_chk++; if (obs_i[i] !== ew[i]) begin n_fail++;
        $display("FAIL dir_instr[%0d] got %h want %h",
                 i, obs_i[i], ew[i]); end
      n_chk++; if (obs_a[i] !== 32'(4 * i)) begin n_fail++;
        $display("FAIL dir_addr[%0d] got %h want %h",
                 i, obs_a[i], 4 * i); end
    end
  endtask

  task automatic test_errors();
    rec_t er[4];
    int   ec[4];
    er[0] = mk(1, 7'h13, 0, 0, 1, 0, 0, 32'h800); ec[0] = 3;
    er[1] = mk(3, 7'h63, 0, 0, 0, 0, 0, 32'h3);   ec[1] = 3;
    er[2] = mk(7, 7'h13, 0, 0, 1, 0, 0, 32'h0);   ec[2] = 1;
    er[3] = mk(1, 7'h11, 0, 0, 1, 0, 0, 32'h0);   ec[3] = 2;
    do_reset();
    stim.push_back(mk(1, 7'h13, 0, 0, 2, 3, 0, 32'h7));
    run(100, 0);
    for (int k = 0; k < 4; k++) begin
      stim.push_back(er[k]);
      run(100, 0);
      n_chk++; if (obs_i.size() != 0) begin n_fail++;
        $display("FAIL err%0d_out got %0d words want 0",
                 k, obs_i.size()); end
      n_chk++; if (obs_c.size() != 1) begin n_fail++;
        $display("FAIL err%0d_pulses got %0d want 1",
                 k, obs_c.size()); end
      else begin
        n_chk++; if (int'(obs_c[0]) != ec[k]) begin n_fail++;
          $display("FAIL err%0d_code got %0d want %0d",
                   k, obs_c[0], ec[k]); end
      end
      n_chk++; if (int'(err_count) != k + 1) begin n_fail++;
        $display("FAIL err%0d_count got %0d want %0d",
                 k, err_count, k + 1); end
    end
    stim.push_back(mk(1, 7'h13, 0, 0, 2, 3, 0, 32'h8));
    run(100, 0);
    n_chk++; if (obs_a.size() != 1 || obs_a[0] !== 32'd4) begin
      n_fail++;
      $display("FAIL err_next_addr got n=%0d a=%h want 00000004",
               obs_a.size(), obs_a.size() ? obs_a[0] : 32'hx);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ew[4];
    logic [31:0] ref_i;
    logic [31:0] ref_a;
    bit          have_ref;
    int          acc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      stim.push_back(mk(1, 7'h13, 3'(i), 0, 5'(i + 1), 5'(i),
                        0, 32'(i * 17)));
      ew[i] = model_word(stim[i]);
    end
    acc = 0;
    have_ref = 1'b0;
    ref_i = '0;
    ref_a = '0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(stim[0]);
      in_valid = 1'b1;
      #2;
      if (in_ready) begin void'(stim.pop_front()); acc++; end
      if (out_valid && have_ref) begin
        n_chk++;
        if (out_instr !== ref_i || out_addr !== ref_a) begin
          n_fail++;
          $display("FAIL bp_stable got %h@%h want %h@%h",
                   out_instr, out_addr, ref_i, ref_a);
        end
      end
      if (out_valid && !have_ref) begin
        have_ref = 1'b1; ref_i = out_instr; ref_a = out_addr;
      end
    end
    n_chk++; if (acc != 2) begin n_fail++;
      $display("FAIL bp_accepted got %0d want 2", acc); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL bp_in_ready got %b want 0", in_ready); end
    n_chk++; if (ref_i !== ew[0]) begin n_fail++;
      $display("FAIL bp_held_word got %h want %h", ref_i, ew[0]); end
    run(100, 0);
    n_chk++; if (obs_i.size() != 4) begin n_fail++;
      $display("FAIL bp_count got %0d want 4", obs_i.size()); end
    for (int i = 0; i < 4 && i < obs_i.size(); i++) begin
      n_chk++;
      if (obs_i[i] !== ew[i] || obs_a[i] !== 32'(4 * i)) begin
        n_fail++;
        $display("FAIL bp_order[%0d] got %h@%h want %h@%h",
                 i, obs_i[i], obs_a[i], ew[i], 4 * i);
      end
    end
  endtask

  task automatic test_addr_load();
    rec_t ra;
    rec_t rb;
    ra = mk(4, 7'h37, 0, 0, 1, 0, 0, 32'hABCD_E000);
    rb = mk(4, 7'h17, 0, 0, 2, 0, 0, 32'h0000_1000);
    do_reset();
    out_ready = 1'b1;
    drive(ra); in_valid = 1'b1;
    @(negedge clk);
    drive(rb);
    @(negedge clk);
    in_valid = 1'b0;
    addr_load = 1'b1; addr_base_in = 32'h100;
    #2;
    n_chk++;
    if (out_valid !== 1'b1 || out_instr !== model_word(ra)
        || out_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL ld_old v=%b %h@%h want 1 %h@00000000",
               out_valid, out_instr, out_addr, model_word(ra));
    end
    @(negedge clk);
    addr_load = 1'b0;
    #2;
    n_chk++;
    if (out_valid !== 1'b1 || out_instr !== model_word(rb)
        || out_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL ld_new v=%b %h@%h want 1 %h@00000100",
               out_valid, out_instr, out_addr, model_word(rb));
    end
    @(negedge clk);
    addr_load = 1'b1; addr_base_in = 32'hFFFF_FFFC;
    @(negedge clk);
    addr_load = 1'b0;
    stim.push_back(ra);
    stim.push_back(rb);
    run(100, 0);
    n_chk++;
    if (obs_a.size() != 2) begin
      n_fail++;
      $display("FAIL wrap_count got %0d want 2", obs_a.size());
    end else begin
      n_chk++; if (obs_a[0] !== 32'hFFFF_FFFC) begin n_fail++;
        $display("FAIL wrap_a0 got %h want fffffffc", obs_a[0]); end
      n_chk++; if (obs_a[1] !== 32'd0) begin n_fail++;
        $display("FAIL wrap_a1 got %h want 0", obs_a[1]); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++)
      stim.push_back(mk(6, 7'h13, 0, 0, 1, 0, 0, 32'd0));
    run(100, 0);
    n_chk++; if (obs_c.size() != 20) begin n_fail++;
      $display("FAIL sat_pulses got %0d want 20", obs_c.size()); end
    n_chk++; if (err_count !== {CW{1'b1}}) begin n_fail++;
      $display("FAIL sat_count got %0d want %0d",
               err_count, (1 << CW) - 1); end
  endtask

  task automatic test_random();
    logic [31:0] ew[$];
    rec_t        er[$];
    int          ec[$];
    int          drops;
    int          n;
    rec_t        r;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = rnd_rec();
      stim.push_back(r);
      if (model_code(r) == 0) begin
        ew.push_back(model_word(r));
        er.push_back(r);
      end else begin
        ec.push_back(model_code(r));
      end
    end
    drops = ec.size();
    run(60, 20);
    n_chk++; if (obs_i.size() != ew.size()) begin n_fail++;
      $display("FAIL rnd_count got %0d want %0d",
               obs_i.size(), ew.size()); end
    n = (obs_i.size() < ew.size()) ? obs_i.size() : ew.size();
    for (int i = 0; i < n; i++) begin
      n_chk++;
      if (obs_i[i] !== ew[i] || obs_a[i] !== 32'(4 * i)) begin
        n_fail++;
        $display("FAIL rnd_word[%0d] got %h@%h want %h@%h",
                 i, obs_i[i], obs_a[i], ew[i], 4 * i);
      end
      if (er[i].fmt != 0) begin
        n_chk++;
        if (decode_imm(er[i].fmt, obs_i[i]) !== er[i].imm) begin
          n_fail++;
          $display("FAIL rnd_roundtrip[%0d] got %h want %h",
                   i, decode_imm(er[i].fmt, obs_i[i]), er[i].imm);
        end
      end
    end
    n_chk++; if (obs_c.size() != ec.size()) begin n_fail++;
      $display("FAIL rnd_drops got %0d want %0d",
               obs_c.size(), ec.size()); end
    n = (obs_c.size() < ec.size()) ? obs_c.size() : ec.size();
    for (int i = 0; i < n; i++) begin
      n_chk++; if (int'(obs_c[i]) != ec[i]) begin n_fail++;
        $display("FAIL rnd_code[%0d] got %0d want %0d",
                 i, obs_c[i], ec[i]); end
    end
    n_chk++;
    if (int'(err_count) != ((drops > 15) ? 15 : drops)) begin
      n_fail++;
      $display("FAIL rnd_err_count got %0d want %0d", err_count,
               (drops > 15) ? 15 : drops);
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(mk(1, 7'h13, 0, 0, 5'(c + 1), 0, 0, 32'(c)));
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL mrst_out_valid got %b want 0", out_valid); end
    n_chk++; if (out_addr !== 32'd0) begin n_fail++;
      $display("FAIL mrst_out_addr got %h want 0", out_addr); end
    n_chk++; if (err_count !== '0) begin n_fail++;
      $display("FAIL mrst_err_count got %0d want 0", err_count); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL mrst_in_ready got %b want 1", in_ready); end
    seen = 0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #2;
      if (out_valid) seen++;
    end
    n_chk++; if (seen != 0) begin n_fail++;
      $display("FAIL mrst_flushed got %0d words want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_itype_latency();
    test_directed_stream();
    test_errors();
    test_backpressure();
    test_addr_load();
    test_saturation();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
